// File: rtl/fir_parallel_3_ctrl_if.sv
// Stream and core-facing signal bundle for the 3-parallel FIR controller.
// master = controller side, slave = upstream/downstream/core side.
interface fir_parallel_3_ctrl_if #(
  parameter int DW = 16,
  parameter int OW = 32
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [OW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] core_x0, core_x1, core_x2;
  logic          core_start;
  logic [OW-1:0] core_y0, core_y1, core_y2;

  modport master (
    input  s_data, s_valid, m_ready, core_y0, core_y1, core_y2,
    output s_ready, m_data, m_valid, core_x0, core_x1, core_x2, core_start
  );

  modport slave (
    output s_data, s_valid, m_ready, core_y0, core_y1, core_y2,
    input  s_ready, m_data, m_valid, core_x0, core_x1, core_x2, core_start
  );
endinterface

// File: rtl/fir_parallel_3_ctrl.sv
// Packs three stream samples into a block for the 3-parallel FIR core, waits CORE_LAT, replays
// the three results serially. Defining FIR3_CTRL_FLUSH_EN adds a flush input for partial blocks.
module fir_parallel_3_ctrl #(
  parameter int DW       = 16,
  parameter int OW       = 32,
  parameter int CORE_LAT = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef FIR3_CTRL_FLUSH_EN
  input  logic flush,
`endif
  fir_parallel_3_ctrl_if.master bus,
  output logic busy
);
  // state | meaning
  // FILL  | collecting samples into slots 0..2
  // ISSUE | core_start high, block presented on core_x*
  // WAIT  | counting down the core latency
  // DRAIN | replaying buf[0..n-1] on m_data/m_valid
  typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt, n, n_nxt, k, k_nxt;
  logic [1:0]    fill_cnt;
  logic [3:0]    lat_cnt;
  logic [DW-1:0] smp0, smp1, s0, s1;
  logic [OW-1:0] buf0, buf1, buf2;
  logic          accept, flush_req, load_x, capture, m_take, last_out;

  assign accept   = (state == FILL) && bus.s_valid;
  assign fill_cnt = idx + {1'b0, accept};
`ifdef FIR3_CTRL_FLUSH_EN
  assign flush_req = flush && (idx != 2'd0);
`else
  assign flush_req = 1'b0;
`endif
  assign capture  = (state == WAIT) && (lat_cnt == 4'd1);
  assign m_take   = (state == DRAIN) && bus.m_ready;
  assign last_out = (k == n - 2'd1);
  assign load_x   = (state == FILL) && (state_nxt == ISSUE);

  // a sample accepted in the closing cycle lands in its slot before the block is issued
  assign s0 = (accept && idx == 2'd0) ? bus.s_data : smp0;
  assign s1 = (accept && idx == 2'd1) ? bus.s_data : smp1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    n_nxt     = n;
    k_nxt     = k;
    case (state)
      FILL: begin
        if (accept && idx == 2'd2) begin
          state_nxt = ISSUE;
          idx_nxt   = 2'd0;
          n_nxt     = 2'd3;
        end else if (flush_req) begin
          state_nxt = ISSUE;
          idx_nxt   = 2'd0;
          n_nxt     = fill_cnt;
        end else if (accept) begin
          idx_nxt = idx + 2'd1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (capture) state_nxt = DRAIN;
      DRAIN: begin
        if (m_take) begin
          if (last_out) begin
            state_nxt = FILL;
            k_nxt     = 2'd0;
          end else begin
            k_nxt = k + 2'd1;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= 2'd0;
      n           <= 2'd0;
      k           <= 2'd0;
      lat_cnt     <= 4'd0;
      smp0        <= '0;
      smp1        <= '0;
      bus.core_x0 <= '0;
      bus.core_x1 <= '0;
      bus.core_x2 <= '0;
      buf0        <= '0;
      buf1        <= '0;
      buf2        <= '0;
    end else begin
      idx <= idx_nxt;
      n   <= n_nxt;
      k   <= k_nxt;
      if (accept && idx == 2'd0) smp0 <= bus.s_data;
      if (accept && idx == 2'd1) smp1 <= bus.s_data;
      if (load_x) begin
        bus.core_x0 <= s0;
        bus.core_x1 <= (fill_cnt >= 2'd2) ? s1 : '0;
        bus.core_x2 <= (fill_cnt == 2'd3) ? bus.s_data : '0;
      end
      if (state == ISSUE)     lat_cnt <= 4'(CORE_LAT);
      else if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (capture) begin
        buf0 <= bus.core_y0;
        buf1 <= bus.core_y1;
        buf2 <= bus.core_y2;
      end
    end
  end

  // s_ready is gated by reset so every output reads 0 while reset is held
  assign bus.s_ready    = reset && (state == FILL);
  assign bus.core_start = (state == ISSUE);
  assign bus.m_valid    = (state == DRAIN);
  assign bus.m_data     = (k == 2'd0) ? buf0 : (k == 2'd1) ? buf1 : buf2;
  assign busy           = (state != FILL) || (idx != 2'd0);
endmodule

// File: doc/fir_parallel_3_ctrl.md
# fir_parallel_3_ctrl

Stream controller for the 3-parallel (polyphase) FIR core. Accepts a serial valid/ready sample stream, packs three consecutive samples into one block, issues the block to the core with a start strobe, and waits the core's fixed latency. It then captures the three core outputs and replays them as a serial valid/ready output stream. Only one block is in flight at a time.

## Interface
- DW, 16, input sample width (signed)
- OW, 32, core output width (signed)
- CORE_LAT, 2, cycles from the core_start sampling edge to the edge where core_y* is valid; range 1..15
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_data  in  DW  input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- flush  in  1  close a partial block; present only with FIR3_CTRL_FLUSH_EN
- core_x0, core_x1, core_x2  out  DW each  block to core; x0 is the oldest sample
- core_start  out  1  one-cycle block-issue strobe
- core_y0, core_y1, core_y2  in  OW each  core results, phase-aligned with x0..x2
- m_data  out  OW  output sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- busy  out  1  high when state is not FILL, or when idx is not 0

## Operation
- Reset (reset low) applies asynchronously: state FILL, idx 0, lat counter 0, n 0, core_x* 0, core_start 0, m_data 0, m_valid 0, and the output buffer is cleared. s_ready is 1 as soon as reset is released.
- FILL: s_ready=1.
  - On s_valid&&s_ready, store s_data into slot idx, then idx++.
  - Accepting the sample in slot 2 sets n=3, clears idx, and moves to ISSUE.
- ISSUE (1 cycle): core_start=1 and s_ready=0.
  - core_x0..x2 are registered. They stay stable from ISSUE until the next ISSUE.
  - Load the latency counter with CORE_LAT and move to WAIT.
- WAIT: the counter decrements each cycle.
  - On the edge where it reaches 0, capture core_y0..y2 into the output buffer and move to DRAIN.
  - The capture edge is exactly CORE_LAT edges after the edge that sampled core_start high.
- DRAIN: m_valid=1 and m_data = buf[k], with k starting at 0.
  - k advances on m_valid&&m_ready.
  - After buf[n-1] is accepted: m_valid=0, return to FILL.
  - m_data and m_valid hold while m_ready=0.
- No arithmetic is performed. Core outputs pass through bit-exact, with no truncation or saturation.
- s_ready=0 in ISSUE, WAIT and DRAIN. Upstream stalls and no sample is dropped.

## Timing
- Third accept at edge E0. core_start is high during the cycle after E0 and sampled at E0+1.
- Capture occurs at E0+1+CORE_LAT. m_valid is high from that edge.
- Output samples are spaced one cycle apart when m_ready=1.
- Minimum block period: 3 (fill) + 1 (issue) + CORE_LAT + 3 (drain) cycles. This is 9 cycles at the default.
- The first s_ready after a block is 1 cycle after the last m_valid&&m_ready edge.
- Reset asserted in any state forces the reset values within the same cycle. No partial output is emitted after release.

## Configuration
- FIR3_CTRL_FLUSH_EN defined: the flush port exists. Behaviour in FILL:
  - flush=1 with idx>0: the empty slots are zero-filled, n is set to the number of real samples, and the block goes to ISSUE.
  - DRAIN emits only buf[0..n-1].
  - If s_valid&&s_ready occurs in the same cycle, the sample is stored first and n counts it. If that sample completes the block, this is a normal n=3 block.
  - flush with idx=0 is ignored. flush is ignored outside FILL.
- FIR3_CTRL_FLUSH_EN undefined: no flush port and n is always 3. A partial block waits indefinitely for more samples.

## Test plan
Bench core model: CORE_LAT=2, y_k = 3*x_k, sign-extended.

- Reset: hold reset low for 2 cycles mid-stream, then release. Every output is 0 while low, and s_ready=1 in the first cycle after release.
- Impulse: feed 1, 0, 0 back-to-back with m_ready=1.
  - core_start pulses once with x0=1, x1=0, x2=0.
  - m_data is 3, 0, 0 on consecutive cycles, with m_valid rising 3 edges after the third accept.
- Extremes: feed -32768, 32767, -1. Outputs are -98304, 98301, -3, exact in 32 bits.
- Backpressure: hold m_ready=0 for 5 cycles during DRAIN. m_data holds buf[0] with m_valid=1 and s_ready=0; the full sequence completes after release with no loss or duplication.
- Flush (macro on): feed 5 and 7, then pulse flush. Core receives x=5, 7, 0; exactly two outputs 15 and 21 are emitted, then the state returns to FILL.
- Reset in WAIT: assert reset one cycle after core_start. m_valid and core_start are 0 immediately, and the next block 2, 4, 6 yields 6, 12, 18.
